uart_tx_frame: RTL and testbench



---
 rtl/uart_tx_frame.sv | 107 ++++++++++
 tb/tb_uart_tx_frame.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start, LSB-first data, optional parity, stop; one bit per CLK.
// Latency: start bit appears on TX_OUT one cycle after Data_Valid is accepted in IDLE.
// Backpressure: requests seen while Busy=1 are dropped, not queued; caller watches Busy.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  par_en_q;
    logic                  par_en_nxt;
    logic                  par_typ_q;
    logic                  par_typ_nxt;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nxt;
    logic                  tx_nxt;
    logic                  busy_nxt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            cnt       <= '0;
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            data_q    <= data_nxt;
            par_en_q  <= par_en_nxt;
            par_typ_q <= par_typ_nxt;
            cnt       <= cnt_nxt;
            TX_OUT    <= tx_nxt;
            Busy      <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        data_nxt    = data_q;
        par_en_nxt  = par_en_q;
        par_typ_nxt = par_typ_q;
        cnt_nxt     = cnt;
        case (state)
            IDLE: begin
                if (Data_Valid) begin
                    data_nxt    = P_DATA;
                    par_en_nxt  = PAR_EN;
                    par_typ_nxt = PAR_TYP;
                    state_nxt   = START;
                end
            end
            START: begin
                cnt_nxt   = '0;
                state_nxt = DATA;
            end
            DATA: begin
                if (cnt == LAST_BIT) begin
                    state_nxt = par_en_q ? PARITY : STOP;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            PARITY:  state_nxt = STOP;
            STOP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Line value is decoded from the next state so TX_OUT/Busy stay pure flop outputs.
    always_comb begin
        tx_nxt   = 1'b1;
        busy_nxt = (state_nxt != IDLE);
        case (state_nxt)
            IDLE:    tx_nxt = 1'b1;
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = data_q[cnt_nxt];
            PARITY:  tx_nxt = (^data_q) ^ par_typ_q;
            STOP:    tx_nxt = 1'b1;
            default: tx_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: table of frames plus reset, back-to-back and width-5 cases.
module tb_uart_tx_frame;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] p_data = 8'h00;
    logic       dv = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       tx_out;
    logic       busy;

    logic [4:0] p_data5 = 5'b0;
    logic       dv5 = 1'b0;
    logic       par_en5 = 1'b0;
    logic       par_typ5 = 1'b0;
    logic       tx_out5;
    logic       busy5;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(p_data), .Data_Valid(dv),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .TX_OUT(tx_out), .Busy(busy)
    );

    uart_tx_frame #(.DATA_WIDTH(5)) dut5 (
        .CLK(CLK), .RST(RST), .P_DATA(p_data5), .Data_Valid(dv5),
        .PAR_EN(par_en5), .PAR_TYP(par_typ5), .TX_OUT(tx_out5), .Busy(busy5)
    );

    typedef struct {
        logic [7:0]  d;
        logic        en;
        logic        typ;
        int          len;
        logic [10:0] seq;   // time order reads left to right over the low len bits
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input int id);
        @(negedge CLK);
        p_data  = v.d;
        par_en  = v.en;
        par_typ = v.typ;
        dv      = 1'b1;
        @(negedge CLK);
        dv      = 1'b0;
        p_data  = ~v.d;
        par_en  = ~v.en;
        par_typ = ~v.typ;
        for (int i = 0; i < v.len; i++) begin
            if (i > 0) @(negedge CLK);
            chk($sformatf("vec%0d tx[%0d]", id, i), tx_out, v.seq[v.len-1-i]);
            chk($sformatf("vec%0d busy[%0d]", id, i), busy, 1'b1);
        end
        @(negedge CLK);
        chk($sformatf("vec%0d idle tx", id), tx_out, 1'b1);
        chk($sformatf("vec%0d idle busy", id), busy, 1'b0);
    endtask

    initial begin
        vecs[0] = '{d: 8'hA5, en: 1'b0, typ: 1'b0, len: 10, seq: 11'b0101001011};
        vecs[1] = '{d: 8'hA5, en: 1'b1, typ: 1'b0, len: 11, seq: 11'b01010010101};
        vecs[2] = '{d: 8'h07, en: 1'b1, typ: 1'b1, len: 11, seq: 11'b01110000001};
        vecs[3] = '{d: 8'h80, en: 1'b1, typ: 1'b0, len: 11, seq: 11'b00000000111};
        vecs[4] = '{d: 8'h3C, en: 1'b1, typ: 1'b1, len: 11, seq: 11'b00011110011};
        vecs[5] = '{d: 8'hFF, en: 1'b0, typ: 1'b1, len: 10, seq: 11'b0111111111};

        repeat (3) @(negedge CLK);
        chk("reset tx", tx_out, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset tx5", tx_out5, 1'b1);
        chk("reset busy5", busy5, 1'b0);
        RST = 1'b0;
        @(negedge CLK);
        chk("post reset tx", tx_out, 1'b1);
        chk("post reset busy", busy, 1'b0);

        for (int k = 0; k < 6; k++) run_frame(vecs[k], k);

        // Reset during data bit 3, with a same-cycle request that must be dropped.
        @(negedge CLK);
        p_data = 8'hA5; par_en = 1'b0; dv = 1'b1;
        @(negedge CLK);
        dv = 1'b0;
        repeat (4) @(negedge CLK);
        chk("mid bit3 tx", tx_out, 1'b0);
        RST = 1'b1; dv = 1'b1;
        @(negedge CLK);
        chk("rst mid tx", tx_out, 1'b1);
        chk("rst mid busy", busy, 1'b0);
        RST = 1'b0; dv = 1'b0;
        @(negedge CLK);
        chk("rst drop tx", tx_out, 1'b1);
        chk("rst drop busy", busy, 1'b0);
        run_frame(vecs[0], 10);

        // Back-to-back with Data_Valid held, data change and a pulse while busy.
        @(negedge CLK);
        p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0; dv = 1'b1;
        for (int i = 0; i < 23; i++) begin
            logic etx;
            logic ebusy;
            @(negedge CLK);
            if (i == 3) p_data = 8'hFF;
            if (i == 4) dv = 1'b0;
            if (i == 6) dv = 1'b1;
            if (i == 12) dv = 1'b0;
            etx   = !(i == 0 || i == 11 || (i >= 1 && i <= 8));
            ebusy = !(i == 10 || i >= 21);
            chk($sformatf("b2b tx[%0d]", i), tx_out, etx);
            chk($sformatf("b2b busy[%0d]", i), busy, ebusy);
        end

        // Width-5 variant: 5'b10011, even parity.
        begin
            logic [7:0] seq5;
            seq5 = 8'b01100111;
            @(negedge CLK);
            p_data5 = 5'b10011; par_en5 = 1'b1; par_typ5 = 1'b0; dv5 = 1'b1;
            @(negedge CLK);
            dv5 = 1'b0; p_data5 = 5'b01100;
            for (int i = 0; i < 8; i++) begin
                if (i > 0) @(negedge CLK);
                chk($sformatf("w5 tx[%0d]", i), tx_out5, seq5[7-i]);
                chk($sformatf("w5 busy[%0d]", i), busy5, 1'b1);
            end
            @(negedge CLK);
            chk("w5 idle tx", tx_out5, 1'b1);
            chk("w5 idle busy", busy5, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
